// File: rtl/button_conditioner.sv
// Button front end: two-flop synchroniser, per-button debounce, sticky press-event flags with ack/overrun.
// Define BUTTON_CONDITIONER_REPEAT_EN to add hold-to-repeat events on left/right.
module button_conditioner #(
  parameter int DB_CYCLES     = 250000,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_throw,
  input  logic       btn_start,
  input  logic       btn_restart,
  input  logic [4:0] evt_ack,
  output logic [4:0] evt,
  output logic [4:0] evt_overrun,
  output logic [4:0] btn_level
);

  localparam int DW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
  localparam logic [DW-1:0] DB_LAST = DW'(DB_CYCLES - 1);

  if (DB_CYCLES < 2 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_bad_param
    $error("button_conditioner: DB_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must be >= 2");
  end

  logic [4:0] raw;
  logic [4:0] s1;
  logic [4:0] s2;
  logic [4:0] stable;
  logic [4:0] press_evt;
  logic [4:0] rep_evt;
  logic [4:0] new_evt;

  assign raw = {btn_restart, btn_start, btn_throw, btn_right, btn_left};

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // Any cycle of agreement restarts the count, so only a full run of disagreement flips stable.
  for (genvar i = 0; i < 5; i++) begin : g_db
    logic [DW-1:0] cnt;
    logic          stb;

    always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
        cnt <= '0;
        stb <= 1'b0;
      end else if (s2[i] == stb) begin
        cnt <= '0;
      end else if (cnt == DB_LAST) begin
        stb <= s2[i];
        cnt <= '0;
      end else begin
        cnt <= cnt + DW'(1);
      end
    end

    assign stable[i]    = stb;
    assign press_evt[i] = s2[i] && !stb && (cnt == DB_LAST);
  end

`ifdef BUTTON_CONDITIONER_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int HW   = $clog2(RMAX);
  localparam logic [HW-1:0] DELAY_LOAD  = HW'(REPEAT_DELAY - 1);
  localparam logic [HW-1:0] PERIOD_LOAD = HW'(REPEAT_PERIOD - 1);

  // Down-counter loaded at the press; terminal count while still held fires a repeat and reloads.
  for (genvar i = 0; i < 2; i++) begin : g_rep
    logic [HW-1:0] hold;

    always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
        hold <= '0;
      end else if (press_evt[i]) begin
        hold <= DELAY_LOAD;
      end else if (!stable[i]) begin
        hold <= '0;
      end else if (hold == '0) begin
        hold <= PERIOD_LOAD;
      end else begin
        hold <= hold - HW'(1);
      end
    end

    assign rep_evt[i] = stable[i] && (hold == '0);
  end

  assign rep_evt[4:2] = '0;
`else
  assign rep_evt = '0;
`endif

  assign new_evt = press_evt | rep_evt;

  // An ack coinciding with a new event keeps the flag set but drops overrun.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      evt         <= '0;
      evt_overrun <= '0;
    end else begin
      evt         <= (evt & ~evt_ack) | new_evt;
      evt_overrun <= (evt_overrun | (new_evt & evt)) & ~evt_ack;
    end
  end

  assign btn_level = stable;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DB_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=3.
module tb_button_conditioner;

  logic       CLK;
  logic       reset;
  logic       btn_left, btn_right, btn_throw, btn_start, btn_restart;
  logic [4:0] evt_ack;
  logic [4:0] evt, evt_overrun, btn_level;

  int n_cmp = 0;
  int n_bad = 0;

  button_conditioner #(
    .DB_CYCLES(4),
    .REPEAT_DELAY(8),
    .REPEAT_PERIOD(3)
  ) dut (
    .CLK(CLK),
    .reset(reset),
    .btn_left(btn_left),
    .btn_right(btn_right),
    .btn_throw(btn_throw),
    .btn_start(btn_start),
    .btn_restart(btn_restart),
    .evt_ack(evt_ack),
    .evt(evt),
    .evt_overrun(evt_overrun),
    .btn_level(btn_level)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    #2;
    n_cmp++; if (evt !== 5'b0) begin n_bad++; $display("FAIL reset_evt: got %b want %b", evt, 5'b0); end
    n_cmp++; if (evt_overrun !== 5'b0) begin n_bad++; $display("FAIL reset_ovr: got %b want %b", evt_overrun, 5'b0); end
    n_cmp++; if (btn_level !== 5'b0) begin n_bad++; $display("FAIL reset_level: got %b want %b", btn_level, 5'b0); end
    step(2);
    reset = 1'b1;
    step(2);
    n_cmp++; if (evt !== 5'b0) begin n_bad++; $display("FAIL idle_evt: got %b want %b", evt, 5'b0); end
  endtask

  task automatic test_clean_press;
    btn_throw = 1'b1;
    step(5);
    n_cmp++; if (evt !== 5'b0) begin n_bad++; $display("FAIL press_early_evt: got %b want %b", evt, 5'b0); end
    n_cmp++; if (btn_level !== 5'b0) begin n_bad++; $display("FAIL press_early_level: got %b want %b", btn_level, 5'b0); end
    step(1);
    n_cmp++; if (evt !== 5'b00100) begin n_bad++; $display("FAIL press_evt: got %b want %b", evt, 5'b00100); end
    n_cmp++; if (btn_level !== 5'b00100) begin n_bad++; $display("FAIL press_level: got %b want %b", btn_level, 5'b00100); end
    step(3);
    n_cmp++; if (evt !== 5'b00100) begin n_bad++; $display("FAIL press_sticky: got %b want %b", evt, 5'b00100); end
    evt_ack = 5'b00100;
    step(1);
    evt_ack = 5'b0;
    n_cmp++; if (evt !== 5'b0) begin n_bad++; $display("FAIL press_ack: got %b want %b", evt, 5'b0); end
    btn_throw = 1'b0;
    step(5);
    n_cmp++; if (btn_level !== 5'b00100) begin n_bad++; $display("FAIL release_early_level: got %b want %b", btn_level, 5'b00100); end
    step(1);
    n_cmp++; if (btn_level !== 5'b0) begin n_bad++; $display("FAIL release_level: got %b want %b", btn_level, 5'b0); end
    n_cmp++; if (evt !== 5'b0) begin n_bad++; $display("FAIL release_no_evt: got %b want %b", evt, 5'b0); end
  endtask

  task automatic test_glitch;
    for (int r = 0; r < 5; r++) begin
      btn_left = 1'b1;
      step(3);
      btn_left = 1'b0;
      step(1);
      n_cmp++; if (evt !== 5'b0) begin n_bad++; $display("FAIL glitch_evt[%0d]: got %b want %b", r, evt, 5'b0); end
      n_cmp++; if (btn_level !== 5'b0) begin n_bad++; $display("FAIL glitch_level[%0d]: got %b want %b", r, btn_level, 5'b0); end
    end
    btn_left = 1'b1;
    step(5);
    n_cmp++; if (evt !== 5'b0) begin n_bad++; $display("FAIL hold_early_evt: got %b want %b", evt, 5'b0); end
    step(1);
    n_cmp++; if (evt !== 5'b00001) begin n_bad++; $display("FAIL hold_evt: got %b want %b", evt, 5'b00001); end
    n_cmp++; if (btn_level !== 5'b00001) begin n_bad++; $display("FAIL hold_level: got %b want %b", btn_level, 5'b00001); end
    evt_ack  = 5'b00001;
    btn_left = 1'b0;
    step(1);
    evt_ack = 5'b0;
    n_cmp++; if (evt !== 5'b0) begin n_bad++; $display("FAIL hold_ack: got %b want %b", evt, 5'b0); end
    step(4);
    n_cmp++; if (btn_level !== 5'b00001) begin n_bad++; $display("FAIL hold_rel_early: got %b want %b", btn_level, 5'b00001); end
    step(1);
    n_cmp++; if (btn_level !== 5'b0) begin n_bad++; $display("FAIL hold_rel_level: got %b want %b", btn_level, 5'b0); end
  endtask

  task automatic test_overrun;
    btn_restart = 1'b1; step(6);
    n_cmp++; if (evt !== 5'b10000) begin n_bad++; $display("FAIL ovr_first_evt: got %b want %b", evt, 5'b10000); end
    n_cmp++; if (evt_overrun !== 5'b0) begin n_bad++; $display("FAIL ovr_first_ovr: got %b want %b", evt_overrun, 5'b0); end
    btn_restart = 1'b0; step(6);
    btn_restart = 1'b1; step(6);
    n_cmp++; if (evt !== 5'b10000) begin n_bad++; $display("FAIL ovr_second_evt: got %b want %b", evt, 5'b10000); end
    n_cmp++; if (evt_overrun !== 5'b10000) begin n_bad++; $display("FAIL ovr_second_ovr: got %b want %b", evt_overrun, 5'b10000); end
    btn_restart = 1'b0; step(6);
    evt_ack = 5'b10000; step(1); evt_ack = 5'b0;
    n_cmp++; if (evt !== 5'b0) begin n_bad++; $display("FAIL ovr_ack_evt: got %b want %b", evt, 5'b0); end
    n_cmp++; if (evt_overrun !== 5'b0) begin n_bad++; $display("FAIL ovr_ack_ovr: got %b want %b", evt_overrun, 5'b0); end
    btn_restart = 1'b1; step(6);
    btn_restart = 1'b0; step(6);
    btn_restart = 1'b1; step(5);
    evt_ack = 5'b10000; step(1); evt_ack = 5'b0;
    n_cmp++; if (evt !== 5'b10000) begin n_bad++; $display("FAIL ovr_coincide_evt: got %b want %b", evt, 5'b10000); end
    n_cmp++; if (evt_overrun !== 5'b0) begin n_bad++; $display("FAIL ovr_coincide_ovr: got %b want %b", evt_overrun, 5'b0); end
    btn_restart = 1'b0; step(6);
    n_cmp++; if (btn_level !== 5'b0) begin n_bad++; $display("FAIL ovr_rel_level: got %b want %b", btn_level, 5'b0); end
  endtask

  task automatic test_reset_mid;
    btn_start = 1'b1;
    step(3);
    n_cmp++; if (evt !== 5'b10000) begin n_bad++; $display("FAIL mid_pending: got %b want %b", evt, 5'b10000); end
    @(posedge CLK);
    #2 reset = 1'b0;
    #1;
    n_cmp++; if (evt !== 5'b0) begin n_bad++; $display("FAIL mid_rst_evt: got %b want %b", evt, 5'b0); end
    n_cmp++; if (evt_overrun !== 5'b0) begin n_bad++; $display("FAIL mid_rst_ovr: got %b want %b", evt_overrun, 5'b0); end
    n_cmp++; if (btn_level !== 5'b0) begin n_bad++; $display("FAIL mid_rst_level: got %b want %b", btn_level, 5'b0); end
    step(2);
    reset = 1'b1;
    step(5);
    n_cmp++; if (evt !== 5'b0) begin n_bad++; $display("FAIL mid_early_evt: got %b want %b", evt, 5'b0); end
    step(1);
    n_cmp++; if (evt !== 5'b01000) begin n_bad++; $display("FAIL mid_evt: got %b want %b", evt, 5'b01000); end
    n_cmp++; if (btn_level !== 5'b01000) begin n_bad++; $display("FAIL mid_level: got %b want %b", btn_level, 5'b01000); end
    btn_start = 1'b0;
    step(6);
    evt_ack = 5'b01000; step(1); evt_ack = 5'b0;
    n_cmp++; if (evt !== 5'b0) begin n_bad++; $display("FAIL mid_ack: got %b want %b", evt, 5'b0); end
  endtask

  task automatic test_repeat;
    logic exp_e;
    btn_right = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      step(1);
`ifdef BUTTON_CONDITIONER_REPEAT_EN
      exp_e = (k == 6) || (k >= 14 && k <= 35 && ((k - 14) % 3) == 0);
`else
      exp_e = (k == 6);
`endif
      n_cmp++; if (evt[1] !== exp_e) begin n_bad++; $display("FAIL repeat_evt@%0d: got %b want %b", k, evt[1], exp_e); end
      if (k == 35) begin
        n_cmp++; if (btn_level[1] !== 1'b1) begin n_bad++; $display("FAIL repeat_level@35: got %b want 1", btn_level[1]); end
      end
      if (k == 36) begin
        n_cmp++; if (btn_level[1] !== 1'b0) begin n_bad++; $display("FAIL repeat_level@36: got %b want 0", btn_level[1]); end
      end
      evt_ack = exp_e ? 5'b00010 : 5'b0;
      if (k == 30) btn_right = 1'b0;
    end
    evt_ack = 5'b0;
    n_cmp++; if (evt_overrun !== 5'b0) begin n_bad++; $display("FAIL repeat_ovr: got %b want %b", evt_overrun, 5'b0); end
  endtask

  initial begin
    reset = 1'b0;
    btn_left = 1'b0; btn_right = 1'b0; btn_throw = 1'b0;
    btn_start = 1'b0; btn_restart = 1'b0;
    evt_ack = 5'b0;
    test_reset();
    test_clean_press();
    test_glitch();
    test_overrun();
    test_reset_mid();
    test_repeat();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Front-end input stage for the brick-breaker game core. It takes the five raw push-buttons (left, right, throw, start, restart), synchronises and debounces each one, and turns presses into sticky event flags. The game core consumes those flags and clears them with a per-bit acknowledge. It also exports the clean debounced levels, so `start` can keep being used as a level. The block sits between the board pins and the game-logic stage and runs on the board clock.

## Interface

Parameters:
- `DB_CYCLES`, default 250000: consecutive `CLK` cycles a synchronised input must differ from the stable state before the stable state flips (5 ms at 50 MHz). Minimum 2.
- `REPEAT_DELAY`, default 25000000: hold time in `CLK` cycles from the press event to the first auto-repeat event (0.5 s). Minimum 2.
- `REPEAT_PERIOD`, default 5000000: cycles between subsequent auto-repeat events (0.1 s). Minimum 2.

Ports (index map for all 5-bit buses: [0] left, [1] right, [2] throw, [3] start, [4] restart):
- `CLK`  in  1  board clock; single clock domain.
- `reset`  in  1  asynchronous, active-low reset.
- `btn_left`, `btn_right`, `btn_throw`, `btn_start`, `btn_restart`  in  1 each  raw, active-high, asynchronous button pins.
- `evt_ack`  in  5  per-bit synchronous clear of `evt` and `evt_overrun`, one `CLK` cycle wide.
- `evt`  out  5  sticky press-event flags.
- `evt_overrun`  out  5  sticky flag: a new event arrived while `evt` was already set and not acked.
- `btn_level`  out  5  debounced button levels.

## Operation

- **Synchroniser:** per button, two flops. `s2` is the raw value delayed by 2 edges.
- **Debounce,** per button; counter width is `$clog2(DB_CYCLES)`.
  - While `s2` equals `stable`, the counter is held at 0.
  - While they differ, the counter increments each cycle.
  - When the counter equals `DB_CYCLES-1` and they still differ, `stable` takes `s2` and the counter goes to 0.
  - Any single cycle of agreement resets the counter, so glitches shorter than `DB_CYCLES` cycles are rejected.
- **Level output:** `btn_level` = `stable`, registered.
- **Press event:** raised on the edge where `stable` goes 0→1. Release generates nothing.
- **Flag update,** per bit, at each edge:
  - If `evt_ack` and a new event coincide: `evt` stays 1 and `evt_overrun` goes to 0.
  - If `evt_ack` only: `evt` goes to 0 and `evt_overrun` goes to 0.
  - If a new event arrives while `evt` = 1 and no ack: `evt_overrun` goes to 1.
  - If a new event arrives while `evt` = 0: `evt` goes to 1.
- **Ack with nothing pending:** no effect.
- **Reset:** all of the following are 0 while `reset` = 0:
  - synchroniser flops, `stable`, all counters;
  - `evt`, `evt_overrun`, `btn_level`.
- **Button held through reset release:** it is seen as a fresh 0→1 after debounce and produces one event.

## Timing

- Raw rise settled before edge 1 → `s2` = 1 after edge 2 → `stable`, `btn_level` and `evt` all go to 1 on edge `DB_CYCLES+2`.
  - Press latency is `DB_CYCLES+2` cycles.
  - Release latency to `btn_level` = 0 is identical.
- `evt` is visible the cycle after the setting edge.
- An ack sampled at edge n clears the flag on edge n, so the flag reads 0 in the following cycle.
- No output depends combinationally on any input.
- Reset assertion clears all outputs immediately, without waiting for a clock. This includes mid-debounce and mid-repeat.
- After reset release, the first synchroniser capture is on the first rising edge.

## Configuration

- Macro `BUTTON_CONDITIONER_REPEAT_EN` compiles in auto-repeat.
- **Defined,** for left and right only:
  - A hold counter starts at the press event.
  - After `REPEAT_DELAY` further cycles with `stable` = 1, an extra event is generated.
  - After that, an event is generated every `REPEAT_PERIOD` cycles while the button is held.
  - Release (`stable` goes to 0) or reset stops repeating and zeroes the counter.
  - Repeat events follow the same flag, ack and overrun rules as press events.
- **Undefined:** no hold counters are present, and each press yields exactly one event. Throw, start and restart never repeat in either build.

## Test plan

Use `DB_CYCLES=4`, `REPEAT_DELAY=8`, `REPEAT_PERIOD=3` throughout.

- **Clean press:** hold `btn_throw` 1 from cycle 0 → `evt[2]` and `btn_level[2]` rise on edge 6. `evt[2]` stays 1 until `evt_ack[2]` is pulsed, then reads 0 the next cycle. No event on release.
- **Glitch rejection:** toggle `btn_left` 1 for 3 cycles, 0 for 1 cycle, repeated 5 times → `evt[0]` and `btn_level[0]` stay 0. Then hold 1 → `evt[0]` rises 6 edges after the hold begins.
- **Overrun:** two clean presses of `btn_restart` with no ack → `evt[4]` = 1 and `evt_overrun[4]` = 1. `evt_ack[4]` clears both. A third press whose event edge coincides with an ack → `evt[4]` = 1, `evt_overrun[4]` = 0.
- **Reset mid-debounce:** `btn_start` held; pull `reset` low at edge 4 for 2 cycles → all outputs 0 immediately. After release, `evt[3]` rises 6 edges after the first post-reset edge.
- **Auto-repeat with macro defined:** hold `btn_right` 30 cycles → press event at edge 6, repeats at edges 14, 17, 20, … (each acked immediately). Release → no more events after release is debounced.
- **Auto-repeat with macro undefined:** same stimulus → exactly one event at edge 6.
